// File: rtl/marble_dispense_ctrl.sv
// Marble dispenser sequencer: latches a 0..3 marble request, opens the gate once per
// marble, confirms each drop with a synchronized photo-interrupter edge and faults on a miss.
module marble_dispense_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned SETTLE_CYCLES  = 10_000_000,
  parameter int unsigned TIMER_W        = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] marble,
  input  logic       clear,
  input  logic       marble_seen_raw,
  output logic       gate_open,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [1:0] dispensed
);

  typedef enum logic [2:0] {
    IDLE,
    OPEN,
    SETTLE,
    DONE,
    FAULT
  } state_t;

  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);

  state_t             state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic [1:0]         target, target_next;
  logic [1:0]         dispensed_next;
  logic               s1, s2, s3;
  logic               seen;

  // Two flops of metastability protection, the third only for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= marble_seen_raw;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign seen = s2 & ~s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      target    <= 2'd0;
      dispensed <= 2'd0;
      gate_open <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      target    <= target_next;
      dispensed <= dispensed_next;
      gate_open <= (state_next == OPEN);
      busy      <= (state_next != IDLE);
      done      <= (state_next == DONE);
      fault     <= (state_next == FAULT);
    end
  end

  // The timer defaults to zero, so every state change leaves it cleared for the next phase.
  always_comb begin
    state_next     = state;
    timer_next     = '0;
    target_next    = target;
    dispensed_next = dispensed;
    case (state)
      IDLE: begin
        if (start) begin
          target_next    = marble;
          dispensed_next = 2'd0;
          state_next     = (marble == 2'b00) ? DONE : OPEN;
        end
      end
      OPEN: begin
        if (seen) begin
          dispensed_next = dispensed + 2'd1;
          state_next     = SETTLE;
        end else if (timer == TIMEOUT_LAST) begin
          state_next = FAULT;
        end else begin
          timer_next = timer + TIMER_ONE;
        end
      end
      SETTLE: begin
        if (timer == SETTLE_LAST) begin
          state_next = (dispensed == target) ? DONE : OPEN;
        end else begin
          timer_next = timer + TIMER_ONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      FAULT: begin
        if (clear) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
